riscv_mem_arbiter: RTL and testbench

- Shares one single-outstanding memory bus port between instruction fetch (IF) and data access (MEM stage) in the pipelined RV32I core.
- Sequences each bus transaction through request, grant and response.
- Returns data to the owner and drives per-stage stall outputs, which the core ORs into its pipeline stall/flush logic.
- MEM has fixed priority over IF.

---
 rtl/riscv_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - IF/MEM arbiter for a single-outstanding memory bus
//
// Ports:
//   i_clk, i_rstn                      clock, asynchronous active-low reset
//   i_if_req/i_if_addr/i_if_kill       instruction fetch request and redirect kill
//   o_if_rdata/o_if_valid/o_if_stall   fetch result and fetch-stage hold
//   i_mem_req/we/be/addr/wdata         data access request (load or store)
//   o_mem_rdata/o_mem_valid/o_mem_stall data result and MEM-stage hold
//   o_bus_req/we/be/addr/wdata         request to the shared bus
//   i_bus_gnt/i_bus_rvalid/i_bus_rdata bus accept and response

module riscv_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    input  logic                i_if_kill,
    output logic [DATA_W-1:0]   o_if_rdata,
    output logic                o_if_valid,
    output logic                o_if_stall,
    input  logic                i_mem_req,
    input  logic                i_mem_we,
    input  logic [DATA_W/8-1:0] i_mem_be,
    input  logic [ADDR_W-1:0]   i_mem_addr,
    input  logic [DATA_W-1:0]   i_mem_wdata,
    output logic [DATA_W-1:0]   o_mem_rdata,
    output logic                o_mem_valid,
    output logic                o_mem_stall,
    output logic                o_bus_req,
    output logic                o_bus_we,
    output logic [DATA_W/8-1:0] o_bus_be,
    output logic [ADDR_W-1:0]   o_bus_addr,
    output logic [DATA_W-1:0]   o_bus_wdata,
    input  logic                i_bus_gnt,
    input  logic                i_bus_rvalid,
    input  logic [DATA_W-1:0]   i_bus_rdata
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } owner_t;

    state_t              state_q;
    owner_t              owner_q;
    logic                killed_q;
    logic                we_q;
    logic [BE_W-1:0]     be_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   mem_rdata_q;

    logic                kill_hit;
    logic                if_valid;
    logic                mem_valid;

    // A redirect only matters to a fetch that is already on the bus.
    assign kill_hit = i_if_kill && (owner_q == OWN_IF);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_NONE;
            killed_q    <= 1'b0;
            we_q        <= 1'b0;
            be_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_mem_req) begin
                        owner_q <= OWN_MEM;
                        we_q    <= i_mem_we;
                        be_q    <= i_mem_be;
                        addr_q  <= i_mem_addr;
                        wdata_q <= i_mem_wdata;
                        state_q <= S_REQ;
                    end else if (i_if_req && !i_if_kill) begin
                        // wdata_q is left alone: it is never used by a read.
                        owner_q <= OWN_IF;
                        we_q    <= 1'b0;
                        be_q    <= '1;
                        addr_q  <= i_if_addr;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    // The request stays up even when killed; the bus has seen it.
                    if (kill_hit) begin
                        killed_q <= 1'b1;
                    end
                    if (i_bus_gnt) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (kill_hit) begin
                        killed_q <= 1'b1;
                    end
                    if (i_bus_rvalid) begin
                        state_q <= S_RESP;
                        if (!we_q) begin
                            if (owner_q == OWN_MEM) begin
                                mem_rdata_q <= i_bus_rdata;
                            end else begin
                                if_rdata_q <= i_bus_rdata;
                            end
                        end
                    end
                end
                S_RESP: begin
                    state_q  <= S_IDLE;
                    owner_q  <= OWN_NONE;
                    killed_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // A kill arriving in the response cycle itself still suppresses the pulse.
    assign mem_valid = (state_q == S_RESP) && (owner_q == OWN_MEM);
    assign if_valid  = (state_q == S_RESP) && (owner_q == OWN_IF) && !killed_q && !i_if_kill;

    assign o_bus_req   = (state_q == S_REQ);
    assign o_bus_we    = we_q;
    assign o_bus_be    = be_q;
    assign o_bus_addr  = addr_q;
    assign o_bus_wdata = wdata_q;

    assign o_if_rdata  = if_rdata_q;
    assign o_mem_rdata = mem_rdata_q;
    assign o_if_valid  = if_valid;
    assign o_mem_valid = mem_valid;

    assign o_mem_stall = i_mem_req && !mem_valid;
    assign o_if_stall  = i_if_req && !if_valid;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - self-checking bench for riscv_mem_arbiter

module tb_riscv_mem_arbiter;

    logic        clk;
    logic        rstn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        mem_stall;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_if_req     (if_req),
        .i_if_addr    (if_addr),
        .i_if_kill    (if_kill),
        .o_if_rdata   (if_rdata),
        .o_if_valid   (if_valid),
        .o_if_stall   (if_stall),
        .i_mem_req    (mem_req),
        .i_mem_we     (mem_we),
        .i_mem_be     (mem_be),
        .i_mem_addr   (mem_addr),
        .i_mem_wdata  (mem_wdata),
        .o_mem_rdata  (mem_rdata),
        .o_mem_valid  (mem_valid),
        .o_mem_stall  (mem_stall),
        .o_bus_req    (bus_req),
        .o_bus_we     (bus_we),
        .o_bus_be     (bus_be),
        .o_bus_addr   (bus_addr),
        .o_bus_wdata  (bus_wdata),
        .i_bus_gnt    (bus_gnt),
        .i_bus_rvalid (bus_rvalid),
        .i_bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per clock cycle. exp = {bus_req, if_valid, mem_valid, if_stall, mem_stall}.
    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        ik;
        logic        mr;
        logic        g;
        logic        rv;
        logic [31:0] rd;
        logic [4:0]  exp;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic        is_mem;
        logic [31:0] data;
    } rsp_t;

    vec_t tbl[$];
    bus_t bus_q[$];
    rsp_t rsp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cur_test = 0;

    // MEM-side attributes for the current test; held constant through a table.
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;

    function automatic vec_t v(input logic ir, input logic [31:0] ia, input logic ik,
                               input logic mr, input logic g, input logic rv,
                               input logic [31:0] rd, input logic [4:0] e);
        vec_t r;
        r.ir = ir; r.ia = ia; r.ik = ik; r.mr = mr;
        r.g = g; r.rv = rv; r.rd = rd; r.exp = e;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic exp_bus(input logic [31:0] a, input logic we, input logic [3:0] be,
                           input logic [31:0] wd);
        bus_t b;
        b.addr = a; b.we = we; b.be = be; b.wdata = wd;
        bus_q.push_back(b);
    endtask

    task automatic exp_rsp(input logic is_mem, input logic [31:0] d);
        rsp_t r;
        r.is_mem = is_mem; r.data = d;
        rsp_q.push_back(r);
    endtask

    task automatic step(input vec_t x, input int c);
        string p;
        bus_t  b;
        rsp_t  r;
        @(posedge clk);
        #1;
        if_req     = x.ir;
        if_addr    = x.ia;
        if_kill    = x.ik;
        mem_req    = x.mr;
        mem_we     = m_we;
        mem_be     = m_be;
        mem_addr   = m_addr;
        mem_wdata  = m_wdata;
        bus_gnt    = x.g;
        bus_rvalid = x.rv;
        bus_rdata  = x.rd;
        @(negedge clk);
        p = $sformatf("t%0d.c%0d", cur_test, c);
        chk({p, " bus_req"},   bus_req,   x.exp[4]);
        chk({p, " if_valid"},  if_valid,  x.exp[3]);
        chk({p, " mem_valid"}, mem_valid, x.exp[2]);
        chk({p, " if_stall"},  if_stall,  x.exp[1]);
        chk({p, " mem_stall"}, mem_stall, x.exp[0]);
        // Every REQ cycle must present the expected transaction unchanged.
        if (bus_req) begin
            chk({p, " bus_expected"}, bus_q.size() != 0, 1);
            if (bus_q.size() != 0) begin
                b = bus_q[0];
                chk({p, " bus_addr"}, bus_addr, b.addr);
                chk({p, " bus_we"},   bus_we,   b.we);
                chk({p, " bus_be"},   bus_be,   b.be);
                if (b.we) chk({p, " bus_wdata"}, bus_wdata, b.wdata);
                if (bus_gnt) void'(bus_q.pop_front());
            end
        end
        if (if_valid || mem_valid) begin
            chk({p, " rsp_expected"}, rsp_q.size() != 0, 1);
            if (rsp_q.size() != 0) begin
                r = rsp_q.pop_front();
                chk({p, " rsp_owner"}, mem_valid, r.is_mem);
                chk({p, " rsp_data"}, r.is_mem ? mem_rdata : if_rdata, r.data);
            end
        end
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) step(tbl[i], i);
        tbl.delete();
    endtask

    task automatic zero_inputs();
        if_req = 0; if_addr = 0; if_kill = 0;
        mem_req = 0; mem_we = 0; mem_be = 0; mem_addr = 0; mem_wdata = 0;
        bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " bus_req"},   bus_req,   0);
        chk({nm, " bus_we"},    bus_we,    0);
        chk({nm, " bus_be"},    bus_be,    0);
        chk({nm, " bus_addr"},  bus_addr,  0);
        chk({nm, " bus_wdata"}, bus_wdata, 0);
        chk({nm, " if_valid"},  if_valid,  0);
        chk({nm, " mem_valid"}, mem_valid, 0);
        chk({nm, " if_stall"},  if_stall,  0);
        chk({nm, " mem_stall"}, mem_stall, 0);
        chk({nm, " if_rdata"},  if_rdata,  0);
        chk({nm, " mem_rdata"}, mem_rdata, 0);
    endtask

    initial begin
        rstn = 1'b0;
        zero_inputs();
        m_we = 0; m_be = 4'hF; m_addr = 0; m_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rstn = 1'b1;

        // 1: isolated fetch
        cur_test = 1;
        exp_bus(32'h100, 0, 4'hF, 0);
        exp_rsp(0, 32'h00500093);
        tbl.push_back(v(1, 32'h100, 0, 0, 0, 0, 0,            5'b00010));
        tbl.push_back(v(1, 32'h100, 0, 0, 1, 0, 0,            5'b10010));
        tbl.push_back(v(1, 32'h100, 0, 0, 0, 1, 32'h00500093, 5'b00010));
        tbl.push_back(v(1, 32'h100, 0, 0, 0, 0, 0,            5'b01000));
        tbl.push_back(v(0, 32'h0,   0, 0, 0, 0, 0,            5'b00000));
        run_tbl();

        // 2: simultaneous IF and MEM load; MEM first
        cur_test = 2;
        m_we = 0; m_be = 4'hF; m_addr = 32'h2000; m_wdata = 0;
        exp_bus(32'h2000, 0, 4'hF, 0);
        exp_rsp(1, 32'hCAFEF00D);
        exp_bus(32'h104, 0, 4'hF, 0);
        exp_rsp(0, 32'h00000013);
        tbl.push_back(v(1, 32'h104, 0, 1, 0, 0, 0,            5'b00011));
        tbl.push_back(v(1, 32'h104, 0, 1, 1, 0, 0,            5'b10011));
        tbl.push_back(v(1, 32'h104, 0, 1, 0, 1, 32'hCAFEF00D, 5'b00011));
        tbl.push_back(v(1, 32'h104, 0, 1, 0, 0, 0,            5'b00110));
        tbl.push_back(v(1, 32'h104, 0, 0, 0, 0, 0,            5'b00010));
        tbl.push_back(v(1, 32'h104, 0, 0, 1, 0, 0,            5'b10010));
        tbl.push_back(v(1, 32'h104, 0, 0, 0, 1, 32'h00000013, 5'b00010));
        tbl.push_back(v(1, 32'h104, 0, 0, 0, 0, 0,            5'b01000));
        tbl.push_back(v(0, 32'h0,   0, 0, 0, 0, 0,            5'b00000));
        run_tbl();

        // 3: store with grant delayed 3 cycles; load data must survive
        cur_test = 3;
        m_we = 1; m_be = 4'h3; m_addr = 32'h2004; m_wdata = 32'hDEADBEEF;
        exp_bus(32'h2004, 1, 4'h3, 32'hDEADBEEF);
        exp_rsp(1, 32'hCAFEF00D);
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0,            5'b00001));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0,            5'b10001));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0,            5'b10001));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0,            5'b10001));
        tbl.push_back(v(0, 0, 0, 1, 1, 0, 0,            5'b10001));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0,            5'b00001));
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 32'h12345678, 5'b00001));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0,            5'b00100));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0,            5'b00000));
        run_tbl();
        m_we = 0; m_be = 4'hF; m_addr = 0; m_wdata = 0;

        // 4: fetch killed in WAIT, redirected fetch follows
        cur_test = 4;
        exp_bus(32'h108, 0, 4'hF, 0);
        exp_bus(32'h200, 0, 4'hF, 0);
        exp_rsp(0, 32'h0000006F);
        tbl.push_back(v(1, 32'h108, 0, 0, 0, 0, 0,            5'b00010));
        tbl.push_back(v(1, 32'h108, 0, 0, 1, 0, 0,            5'b10010));
        tbl.push_back(v(1, 32'h108, 1, 0, 0, 0, 0,            5'b00010));
        tbl.push_back(v(1, 32'h200, 0, 0, 0, 1, 32'hBADBAD00, 5'b00010));
        tbl.push_back(v(1, 32'h200, 0, 0, 0, 0, 0,            5'b00010));
        tbl.push_back(v(1, 32'h200, 0, 0, 0, 0, 0,            5'b00010));
        tbl.push_back(v(1, 32'h200, 0, 0, 1, 0, 0,            5'b10010));
        tbl.push_back(v(1, 32'h200, 0, 0, 0, 1, 32'h0000006F, 5'b00010));
        tbl.push_back(v(1, 32'h200, 0, 0, 0, 0, 0,            5'b01000));
        tbl.push_back(v(0, 32'h0,   0, 0, 0, 0, 0,            5'b00000));
        run_tbl();

        // kill in IDLE blocks that cycle's fetch grant
        cur_test = 7;
        exp_bus(32'h400, 0, 4'hF, 0);
        exp_rsp(0, 32'h00000022);
        tbl.push_back(v(1, 32'h400, 1, 0, 0, 0, 0,            5'b00010));
        tbl.push_back(v(1, 32'h400, 0, 0, 0, 0, 0,            5'b00010));
        tbl.push_back(v(1, 32'h400, 0, 0, 1, 0, 0,            5'b10010));
        tbl.push_back(v(1, 32'h400, 0, 0, 0, 1, 32'h00000022, 5'b00010));
        tbl.push_back(v(1, 32'h400, 0, 0, 0, 0, 0,            5'b01000));
        tbl.push_back(v(0, 32'h0,   0, 0, 0, 0, 0,            5'b00000));
        run_tbl();

        // 6: spurious rvalid in IDLE and REQ
        cur_test = 6;
        exp_bus(32'h300, 0, 4'hF, 0);
        exp_rsp(0, 32'h11111111);
        tbl.push_back(v(0, 32'h0,   0, 0, 0, 1, 32'hFFFFFFFF, 5'b00000));
        tbl.push_back(v(1, 32'h300, 0, 0, 0, 1, 32'hFFFFFFFF, 5'b00010));
        tbl.push_back(v(1, 32'h300, 0, 0, 0, 1, 32'hFFFFFFFF, 5'b10010));
        tbl.push_back(v(1, 32'h300, 0, 0, 1, 0, 0,            5'b10010));
        tbl.push_back(v(1, 32'h300, 0, 0, 0, 1, 32'h11111111, 5'b00010));
        tbl.push_back(v(1, 32'h300, 0, 0, 0, 0, 0,            5'b01000));
        tbl.push_back(v(0, 32'h0,   0, 0, 0, 0, 0,            5'b00000));
        run_tbl();

        // 5: reset during WAIT, stale rvalid afterwards
        cur_test = 5;
        exp_bus(32'h500, 0, 4'hF, 0);
        tbl.push_back(v(1, 32'h500, 0, 0, 0, 0, 0, 5'b00010));
        tbl.push_back(v(1, 32'h500, 0, 0, 1, 0, 0, 5'b10010));
        tbl.push_back(v(1, 32'h500, 0, 0, 0, 0, 0, 5'b00010));
        run_tbl();
        @(posedge clk);
        #1;
        zero_inputs();
        rstn = 1'b0;
        #1;
        chk_all_zero("t5 in_reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        exp_bus(32'h600, 0, 4'hF, 0);
        exp_rsp(0, 32'h00000033);
        tbl.push_back(v(0, 32'h0,   0, 0, 0, 1, 32'hEEEEEEEE, 5'b00000));
        tbl.push_back(v(0, 32'h0,   0, 0, 0, 1, 32'hEEEEEEEE, 5'b00000));
        tbl.push_back(v(1, 32'h600, 0, 0, 0, 0, 0,            5'b00010));
        tbl.push_back(v(1, 32'h600, 0, 0, 1, 0, 0,            5'b10010));
        tbl.push_back(v(1, 32'h600, 0, 0, 0, 1, 32'h00000033, 5'b00010));
        tbl.push_back(v(1, 32'h600, 0, 0, 0, 0, 0,            5'b01000));
        tbl.push_back(v(0, 32'h0,   0, 0, 0, 0, 0,            5'b00000));
        run_tbl();
        chk("t5 mem_rdata_after_reset", mem_rdata, 0);

        chk("bus_q drained", bus_q.size(), 0);
        chk("rsp_q drained", rsp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
